// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential shift-subtract divider.
// Optional DIVIDER_DBZ_CHECK_EN build: zero divisors complete in one edge without entering RUN.
package divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/divider_datapath.sv
// Restoring-division datapath: partial remainder R, shifting quotient Q, divisor D and result registers.
// Controlled by load/step/capture enables from divider_sequential.
module divider_datapath
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             capture,
    input  logic             capture_dbz,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // R always holds a value below D after a step, so its MSB never feeds the next shift.
    logic unused_r_msb;
    assign unused_r_msb = r_q[WIDTH];

    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_trial = r_shift - {1'b0, d_q};
        r_next  = r_shift;
        q_next  = {q_q[WIDTH-2:0], 1'b0};
        if (!r_trial[WIDTH]) begin
            r_next = r_trial;
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (load) begin
                r_q <= '0;
                q_q <= dividend;
                d_q <= divisor;
            end else if (step) begin
                r_q <= r_next;
                q_q <= q_next;
            end

            // The last step's results are captured on the same edge that performs it.
            if (capture) begin
                quotient  <= q_next;
                remainder <= r_next[WIDTH-1:0];
            end else if (capture_dbz) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end
    end

endmodule

// File: rtl/divider_sequential.sv
// Sequential unsigned divider controller: IDLE/RUN FSM, step counter and start/ready handshake.
// Define DIVIDER_DBZ_CHECK_EN to answer zero-divisor requests in one edge with div_by_zero set.
module divider_sequential
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only in IDLE; ready is a level that rises on completion
    // and falls on the edge that accepts the next start. busy mirrors state == RUN.
    div_state_t    state;
    logic [CW-1:0] cnt;

    logic load;
    logic step;
    logic capture;
    logic accept_dbz;

`ifdef DIVIDER_DBZ_CHECK_EN
    assign accept_dbz = (state == IDLE) && start && (divisor == '0);
`else
    assign accept_dbz = 1'b0;
`endif

    assign load    = (state == IDLE) && start && !accept_dbz;
    assign step    = (state == RUN);
    assign capture = step && (cnt == CW'(1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state       <= RUN;
                        cnt         <= CW'(WIDTH);
                        busy        <= 1'b1;
                        ready       <= 1'b0;
                        div_by_zero <= 1'b0;
                    end else if (accept_dbz) begin
                        ready       <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    divider_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock      (clock),
        .rst_n      (rst_n),
        .load       (load),
        .step       (step),
        .capture    (capture),
        .capture_dbz(accept_dbz),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder)
    );

endmodule

// File: tb/tb_divider_sequential.sv
// Self-checking bench for divider_sequential (WIDTH=8), scoreboard of expected {dbz, quotient, remainder}.
// Honours DIVIDER_DBZ_CHECK_EN when choosing zero-divisor expectations.
module tb_divider_sequential;

    localparam int W = 8;

`ifdef DIVIDER_DBZ_CHECK_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    logic         clock;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ready;
    logic         busy;
    logic         div_by_zero;

    logic [2*W:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    divider_sequential #(
        .WIDTH(W)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one start pulse; immediate=1 drives it in the current cycle (back-to-back).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit immediate);
        if (!immediate) begin
            @(posedge clock);
            #1;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (b == '0) exp_q.push_back({DBZ_EN, {W{1'b1}}, a});
        else         exp_q.push_back({1'b0, W'(a / b), W'(a % b)});
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for ready, then pop the scoreboard and compare.
    task automatic wait_result(input string tag, output int cycles, output int busy_cycles);
        logic [2*W:0] exp;
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        while (!ready && cycles < 50) begin
            @(posedge clock);
            #1;
            cycles++;
            if (busy) busy_cycles++;
        end
        check({tag, "_ready"}, ready, 1);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_dbz"}, div_by_zero, exp[2*W]);
            check({tag, "_quot"}, quotient, exp[2*W-1:W]);
            check({tag, "_rem"}, remainder, exp[W-1:0]);
        end
    endtask

    initial begin
        int cyc;
        int bcyc;
        int busy_seen;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        rst_n = 1'b1;

        // 100/7: 8-cycle latency, busy for exactly 8 cycles
        start_op(8'd100, 8'd7, 1'b0);
        check("basic_busy_after_accept", busy, 1);
        wait_result("basic", cyc, bcyc);
        check("basic_latency", cyc, W);
        check("basic_busy_cycles", bcyc, W);
        check("basic_busy_low", busy, 0);

        // back-to-back 255/1 then 5/9
        start_op(8'd255, 8'd1, 1'b0);
        wait_result("b2b_first", cyc, bcyc);
        check("b2b_first_latency", cyc, W);
        start_op(8'd5, 8'd9, 1'b1);
        check("b2b_ready_drop", ready, 0);
        check("b2b_busy", busy, 1);
        check("b2b_results_held", quotient, 255);
        wait_result("b2b_second", cyc, bcyc);
        check("b2b_second_latency", cyc, W);

        // 42/0
        start_op(8'd42, 8'd0, 1'b0);
        wait_result("dbz", cyc, bcyc);
        check("dbz_latency", cyc, DBZ_EN ? 0 : W);
        check("dbz_busy_cycles", bcyc, DBZ_EN ? 0 : W);

        // 200/3 with a stray start mid-run
        start_op(8'd200, 8'd3, 1'b0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        dividend = 8'd9;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ignore_start_busy", busy, 1);
        wait_result("ignore_start", cyc, bcyc);
        check("ignore_start_latency", cyc, W - 3);
        busy_seen = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (busy) busy_seen++;
        end
        check("ignore_start_no_second_op", busy_seen, 0);
        check("ignore_start_ready_held", ready, 1);
        check("ignore_start_quot_held", quotient, 66);
        check("ignore_start_rem_held", remainder, 2);

        // reset abort mid-run
        start_op(8'd77, 8'd5, 1'b0);
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_quot", quotient, 0);
        check("abort_rem", remainder, 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_abort_ready", ready, 0);
        check("post_abort_busy", busy, 0);
        start_op(8'd77, 8'd5, 1'b0);
        wait_result("post_abort", cyc, bcyc);
        check("post_abort_latency", cyc, W);

        // random sweep with nonzero divisors
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            start_op(a, b, 1'b0);
            wait_result("rand", cyc, bcyc);
            check("rand_latency", cyc, W);
            check("rand_reconstruct", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rand_rem_lt_div", (remainder < b) ? 1 : 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
